mem_port_arbiter: RTL and testbench

- Shares the CPU's single memory port between two requesters: the CPU control path (fetch, immediate, absolute and indirect reads) and a DMA/debug master.
- Sits between the requesters and the memory array.
- Serialises accesses with a fixed-latency access FSM.
- CPU has priority; a starvation guard guarantees DMA forward progress.

---
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: CPU has priority, DMA is forced through
// after STARVE_LIMIT consecutive CPU wins. Fixed-latency IDLE/BUSY/RESP access FSM.
module mem_port_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_done,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [LW-1:0] LAT_LAST   = LW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state_reg, state_next;
  logic          owner_reg;   // 0 = CPU, 1 = DMA
  logic          we_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg;
  logic [DW-1:0] rdata_reg;
  logic [LW-1:0] lat_reg;
  logic [SW-1:0] streak_reg;

  logic start;
  logic dma_win;
  logic last_busy;
  logic first_busy;

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    dma_win    = dma_req && (!cpu_req || streak_reg == STREAK_MAX);
    last_busy  = (state_reg == BUSY) && (lat_reg == LAT_LAST);
    first_busy = (state_reg == BUSY) && (lat_reg == '0);
    case (state_reg)
      IDLE: begin
        if (cpu_req || dma_req) begin
          start      = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY:    if (last_busy) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      owner_reg  <= 1'b0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      lat_reg    <= '0;
      streak_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (start) begin
        owner_reg <= dma_win;
        we_reg    <= dma_win ? dma_we    : cpu_we;
        addr_reg  <= dma_win ? dma_addr  : cpu_addr;
        wdata_reg <= dma_win ? dma_wdata : cpu_wdata;
        lat_reg   <= '0;
        // Streak only grows while DMA is actually waiting behind the CPU.
        if (dma_win || !dma_req)
          streak_reg <= '0;
        else if (streak_reg != STREAK_MAX)
          streak_reg <= streak_reg + SW'(1);
      end else if (state_reg == BUSY) begin
        if (last_busy) begin
          if (!we_reg) rdata_reg <= mem_rdata;
        end else begin
          lat_reg <= lat_reg + LW'(1);
        end
      end
    end
  end

  assign mem_en    = (state_reg == BUSY);
  assign mem_we    = first_busy && we_reg;
  assign mem_addr  = mem_en ? addr_reg  : '0;
  assign mem_wdata = mem_en ? wdata_reg : '0;
  assign cpu_gnt   = first_busy && !owner_reg;
  assign dma_gnt   = first_busy && owner_reg;
  assign cpu_done  = (state_reg == RESP) && !owner_reg;
  assign dma_done  = (state_reg == RESP) && owner_reg;
  assign rdata     = rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance a uses MEM_LAT=1, instance b MEM_LAT=3,
// both driven from the same requester inputs.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;

  logic        a_cpu_gnt, a_cpu_done, a_dma_gnt, a_dma_done, a_mem_en, a_mem_we;
  logic [15:0] a_rdata, a_mem_addr, a_mem_wdata;
  logic        b_cpu_gnt, b_cpu_done, b_dma_gnt, b_dma_done, b_mem_en, b_mem_we;
  logic [15:0] b_rdata, b_mem_addr, b_mem_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(1), .STARVE_LIMIT(4)) u_a (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(a_cpu_gnt), .cpu_done(a_cpu_done),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(a_dma_gnt), .dma_done(a_dma_done),
    .rdata(a_rdata), .mem_en(a_mem_en), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(3), .STARVE_LIMIT(4)) u_b (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(b_cpu_gnt), .cpu_done(b_cpu_done),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(b_dma_gnt), .dma_done(b_dma_done),
    .rdata(b_rdata), .mem_en(b_mem_en), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    logic [53:0] a_all, b_all;
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    mem_rdata = 16'hA5A5;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 2) rst = 1'b0;
      a_all = {a_cpu_gnt, a_cpu_done, a_dma_gnt, a_dma_done, a_mem_en, a_mem_we,
               a_mem_addr, a_mem_wdata, a_rdata};
      b_all = {b_cpu_gnt, b_cpu_done, b_dma_gnt, b_dma_done, b_mem_en, b_mem_we,
               b_mem_addr, b_mem_wdata, b_rdata};
      n_checks++;
      if (a_all !== '0) begin
        n_fail++; $display("FAIL reset_a cycle %0d: outputs %h, want 0", i, a_all);
      end
      n_checks++;
      if (b_all !== '0) begin
        n_fail++; $display("FAIL reset_b cycle %0d: outputs %h, want 0", i, b_all);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_cpu_read();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010; mem_rdata = 16'hBEEF;
    tick();
    n_checks++;
    if ({a_cpu_gnt, a_dma_gnt, a_mem_en, a_mem_we, a_mem_addr} !== {4'b1010, 16'h0010}) begin
      n_fail++;
      $display("FAIL cpu_read_busy: gnt/dgnt/en/we/addr %b%b%b%b %h, want 1010 0010",
               a_cpu_gnt, a_dma_gnt, a_mem_en, a_mem_we, a_mem_addr);
    end
    cpu_req = 0;
    tick();
    n_checks++;
    if ({a_cpu_done, a_cpu_gnt, a_mem_en, a_rdata} !== {3'b100, 16'hBEEF}) begin
      n_fail++;
      $display("FAIL cpu_read_resp: done/gnt/en/rdata %b%b%b %h, want 100 beef",
               a_cpu_done, a_cpu_gnt, a_mem_en, a_rdata);
    end
    tick();
    n_checks++;
    if ({a_cpu_done, a_mem_en, a_rdata} !== {2'b00, 16'hBEEF}) begin
      n_fail++;
      $display("FAIL cpu_read_idle: done/en/rdata %b%b %h, want 00 beef",
               a_cpu_done, a_mem_en, a_rdata);
    end
    idle(6);
    $display("test_cpu_read done");
  endtask

  task automatic test_dma_write();
    dma_req = 1; dma_we = 1; dma_addr = 16'h0100; dma_wdata = 16'h1234; mem_rdata = 16'hDEAD;
    tick();
    n_checks++;
    if ({a_dma_gnt, a_cpu_gnt, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata}
        !== {4'b1011, 16'h0100, 16'h1234}) begin
      n_fail++;
      $display("FAIL dma_write_busy: gnt/cgnt/en/we %b%b%b%b addr %h wdata %h, want 1011 0100 1234",
               a_dma_gnt, a_cpu_gnt, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata);
    end
    dma_req = 0; dma_we = 0;
    tick();
    n_checks++;
    if ({a_dma_done, a_cpu_done, a_mem_we, a_mem_en, a_rdata} !== {4'b1000, 16'hBEEF}) begin
      n_fail++;
      $display("FAIL dma_write_resp: done/cdone/we/en %b%b%b%b rdata %h, want 1000 beef",
               a_dma_done, a_cpu_done, a_mem_we, a_mem_en, a_rdata);
    end
    idle(6);
    $display("test_dma_write done");
  endtask

  task automatic test_starvation();
    logic [9:0] exp_seq = 10'b1000010000;  // bit i set = grant i goes to DMA
    logic [9:0] seq = '0;
    int gcount = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
    dma_req = 1; dma_we = 0; dma_addr = 16'h0200; mem_rdata = 16'h1111;
    for (int c = 0; c < 40 && gcount < 10; c++) begin
      tick();
      n_checks++;
      if ((a_cpu_gnt && a_dma_gnt) || (a_cpu_done && a_dma_done)) begin
        n_fail++;
        $display("FAIL starve_exclusive cycle %0d: gnt %b%b done %b%b, want one-hot",
                 c, a_cpu_gnt, a_dma_gnt, a_cpu_done, a_dma_done);
      end
      if (a_cpu_gnt || a_dma_gnt) begin
        seq[gcount] = a_dma_gnt;
        gcount++;
      end
    end
    n_checks++;
    if (gcount !== 10) begin
      n_fail++; $display("FAIL starve_budget: %0d grants seen, want 10", gcount);
    end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (seq[i] !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL starve_order grant %0d: owner %0d, want %0d (0=cpu 1=dma)",
                 i, seq[i], exp_seq[i]);
      end
    end
    cpu_req = 0; dma_req = 0;
    idle(10);
    $display("test_starvation done");
  endtask

  task automatic test_latency();
    bit exp_en   [5] = '{1, 1, 1, 0, 0};
    bit exp_gnt  [5] = '{1, 0, 0, 0, 0};
    bit exp_done [5] = '{0, 0, 0, 1, 0};
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0030; mem_rdata = 16'hCAFE;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 0) cpu_req = 0;
      n_checks++;
      if ({b_mem_en, b_cpu_gnt, b_cpu_done} !== {exp_en[k], exp_gnt[k], exp_done[k]}) begin
        n_fail++;
        $display("FAIL latency cycle %0d: en/gnt/done %b%b%b, want %b%b%b", k,
                 b_mem_en, b_cpu_gnt, b_cpu_done, exp_en[k], exp_gnt[k], exp_done[k]);
      end
      if (exp_en[k]) begin
        n_checks++;
        if (b_mem_addr !== 16'h0030) begin
          n_fail++; $display("FAIL latency_addr cycle %0d: %h, want 0030", k, b_mem_addr);
        end
      end
    end
    n_checks++;
    if (b_rdata !== 16'hCAFE) begin
      n_fail++; $display("FAIL latency_rdata: %h, want cafe", b_rdata);
    end
    idle(6);
    $display("test_latency done");
  endtask

  task automatic test_reset_mid_access();
    bit done_seen = 0;
    dma_req = 1; dma_we = 0; dma_addr = 16'h0300; mem_rdata = 16'h5555;
    tick();
    n_checks++;
    if (b_dma_gnt !== 1'b1) begin
      n_fail++; $display("FAIL midreset_gnt: dma_gnt %b, want 1", b_dma_gnt);
    end
    dma_req = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    n_checks++;
    if ({b_dma_done, b_mem_en, b_dma_gnt, b_rdata} !== {3'b000, 16'h0000}) begin
      n_fail++;
      $display("FAIL midreset_state: done/en/gnt %b%b%b rdata %h, want 000 0000",
               b_dma_done, b_mem_en, b_dma_gnt, b_rdata);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (b_dma_done || b_mem_en) done_seen = 1;
    end
    n_checks++;
    if (done_seen !== 1'b0) begin
      n_fail++; $display("FAIL midreset_no_done: activity after abort %b, want 0", done_seen);
    end
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040; mem_rdata = 16'h7777;
    done_seen = 0;
    for (int i = 0; i < 12 && !done_seen; i++) begin
      tick();
      if (b_cpu_gnt) cpu_req = 0;
      if (b_cpu_done) done_seen = 1;
    end
    n_checks++;
    if (done_seen !== 1'b1) begin
      n_fail++; $display("FAIL midreset_cpu_done: done seen %b, want 1 within 12 cycles", done_seen);
    end
    n_checks++;
    if (b_rdata !== 16'h7777) begin
      n_fail++; $display("FAIL midreset_cpu_rdata: %h, want 7777", b_rdata);
    end
    cpu_req = 0;
    idle(4);
    $display("test_reset_mid_access done");
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_starvation();
    test_latency();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
